// File: rtl/alu_pkg.sv
// Shared ALU control definitions: ALU_Ctrl codes, RV32I opcodes/funct fields and the
// decoded-op bundle carried through the issue registers.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        illegal;
        logic [3:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
    } alu_op_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode into ALU_Ctrl and the two ALU operands; unsupported
// encodings come out as illegal with a harmless control code and zero operands.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b0000
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [3:0]  ctrl,
    output logic [31:0] src1,
    output logic [31:0] src2,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

    // opcode includes instr[1:0], so a non-11 low pair falls into the default arm
    always_comb begin
        illegal = 1'b0;
        ctrl    = ALU_ADD;
        src1    = rs1;
        src2    = rs2;
        case (opcode)
            OPC_OP: begin
                ctrl    = {instr[30], funct3};
                illegal = !((funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR))));
                if (is_shift) src2 = {27'b0, rs2[4:0]};
            end
            OPC_OP_IMM: begin
                ctrl = {1'b0, funct3};
                src2 = imm_i;
                if (is_shift) begin
                    ctrl    = {instr[30], funct3};
                    src2    = {27'b0, instr[24:20]};
                    illegal = !((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == F3_SR)));
                end
            end
            OPC_LOAD:  src2 = imm_i;
            OPC_STORE: src2 = imm_s;
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE:   ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctrl = ALU_SLTU;
                    default:          illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                src1 = 32'd0;
                src2 = imm_u;
            end
            OPC_AUIPC: begin
                src1 = pc;
                src2 = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                src1 = pc;
                src2 = 32'd4;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = ILLEGAL_CTRL;
            src1 = 32'd0;
            src2 = 32'd0;
        end
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Registered issue stage between register-read and execute for the ALU control interface.
// Build option ALU_CTRL_ISSUE_SKID_EN adds a one-entry skid so in_ready comes from a flop.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int         XLEN         = 32,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [3:0]      ALU_Ctrl,
    output logic            out_illegal
);

    // Handshake: a beat moves on a side only in a cycle where valid && ready are both
    // high at the rising edge; a held output beat keeps every output field unchanged.

    alu_op_t dec_op;
    alu_op_t out_q;
    logic    out_valid_q;

    alu_ctrl_decode #(
        .ILLEGAL_CTRL(ILLEGAL_CTRL)
    ) u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .ctrl   (dec_op.ctrl),
        .src1   (dec_op.src1),
        .src2   (dec_op.src2),
        .illegal(dec_op.illegal)
    );

`ifdef ALU_CTRL_ISSUE_SKID_EN
    alu_op_t skid_q;
    logic    skid_full_q;
    logic    in_fire;
    logic    out_free;

    assign in_ready = !skid_full_q;
    assign in_fire  = in_valid && !skid_full_q;
    assign out_free = !out_valid_q || out_ready;

    // A full skid blocks input, so skid refill and skid drain never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
        end else if (out_free) begin
            if (skid_full_q) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= dec_op;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q      <= dec_op;
            skid_full_q <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (in_valid && in_ready) begin
            out_q       <= dec_op;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid   = out_valid_q;
    assign out_illegal = out_q.illegal;
    assign ALU_Ctrl    = out_q.ctrl;
    assign alu_src1    = out_q.src1;
    assign alu_src2    = out_q.src2;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue: decode vectors, backpressure ordering/stability,
// and reset while stalled.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  ALU_Ctrl;
    logic        out_illegal;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [68:0] exp_q[$];

    always #5 clk = ~clk;

    alu_ctrl_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .ALU_Ctrl   (ALU_Ctrl),
        .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [68:0] cur_op();
        return {out_illegal, ALU_Ctrl, alu_src1, alu_src2};
    endfunction

    function automatic logic [68:0] op(input logic ill, input logic [3:0] c,
                                       input logic [31:0] s1, input logic [31:0] s2);
        return {ill, c, s1, s2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_instr = instr;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        drive(instr, pc, rs1, rs2);
        in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, 69'(in_ready), 69'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_op(input string tag, input logic [68:0] exp);
        check({tag, ".valid"}, 69'(out_valid), 69'd1);
        check({tag, ".op"}, cur_op(), exp);
    endtask

    logic [31:0] bp_instr[4];
    logic [31:0] bp_rs1[4];
    logic [31:0] bp_rs2[4];
    logic [68:0] bp_exp[4];
    logic [68:0] held;
    logic        have_hold;
    logic        exp_rdy;
    logic        in_fire;
    logic        out_fire;
    int          idx;
    int          got;
    int          occ;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        check("rst.out_valid", 69'(out_valid), 69'd0);
        check("rst.op", cur_op(), 69'd0);
        check("rst.in_ready", 69'(in_ready), 69'd1);
        rst_n = 1'b1;
        step();

        // Directed decode vectors, output always ready
        check("lat.pre_valid", 69'(out_valid), 69'd0);
        send("sub", 32'h40B50533, 32'h0, 32'd10, 32'd3);
        expect_op("sub", op(1'b0, 4'h8, 32'd10, 32'd3));
        send("srai", 32'h4041D193, 32'h0, 32'hF000_0000, 32'h0);
        expect_op("srai", op(1'b0, 4'hD, 32'hF000_0000, 32'd4));
        send("srai_bad", 32'h4241D193, 32'h0, 32'hF000_0000, 32'h0);
        expect_op("srai_bad", op(1'b1, 4'h0, 32'd0, 32'd0));
        send("bltu", 32'h0020E063, 32'h0, 32'd1, 32'hFFFF_FFFF);
        expect_op("bltu", op(1'b0, 4'h3, 32'd1, 32'hFFFF_FFFF));
        send("beq", 32'h00208063, 32'h0, 32'd5, 32'd5);
        expect_op("beq", op(1'b0, 4'h8, 32'd5, 32'd5));
        send("br010", 32'h0020A063, 32'h0, 32'd5, 32'd6);
        expect_op("br010", op(1'b1, 4'h0, 32'd0, 32'd0));
        send("auipc", 32'h12345297, 32'h100, 32'hDEAD, 32'h0);
        expect_op("auipc", op(1'b0, 4'h0, 32'h100, 32'h1234_5000));
        send("jal", 32'h0000006F, 32'h200, 32'h0, 32'h0);
        expect_op("jal", op(1'b0, 4'h0, 32'h200, 32'd4));
        send("lui", 32'h123450B7, 32'h0, 32'h55, 32'h0);
        expect_op("lui", op(1'b0, 4'h0, 32'd0, 32'h1234_5000));
        send("sw", 32'hFE20AE23, 32'h0, 32'h1000, 32'h77);
        expect_op("sw", op(1'b0, 4'h0, 32'h1000, 32'hFFFF_FFFC));
        send("addi_b30", 32'h40008093, 32'h0, 32'd7, 32'h0);
        expect_op("addi_b30", op(1'b0, 4'h0, 32'd7, 32'h400));
        send("sll", 32'h002090B3, 32'h0, 32'd1, 32'h25);
        expect_op("sll", op(1'b0, 4'h1, 32'd1, 32'd5));
        send("and_alt", 32'h40B57533, 32'h0, 32'd1, 32'd2);
        expect_op("and_alt", op(1'b1, 4'h0, 32'd0, 32'd0));
        send("low_bits", 32'h40B50531, 32'h0, 32'd1, 32'd2);
        expect_op("low_bits", op(1'b1, 4'h0, 32'd0, 32'd0));
        send("addi_neg", 32'hFFF00093, 32'h0, 32'd9, 32'h0);
        expect_op("addi_neg", op(1'b0, 4'h0, 32'd9, 32'hFFFF_FFFF));
        step();
        check("drain.valid", 69'(out_valid), 69'd0);

        // Backpressure: 4 back-to-back ops, out_ready low on cycles 1..3
        bp_instr[0] = 32'h00108093; bp_rs1[0] = 32'h1000;  bp_rs2[0] = 32'h0;
        bp_exp[0]   = op(1'b0, 4'h0, 32'h1000, 32'd1);
        bp_instr[1] = 32'h00208093; bp_rs1[1] = 32'h2000;  bp_rs2[1] = 32'h0;
        bp_exp[1]   = op(1'b0, 4'h0, 32'h2000, 32'd2);
        bp_instr[2] = 32'h40B50533; bp_rs1[2] = 32'd50;    bp_rs2[2] = 32'd7;
        bp_exp[2]   = op(1'b0, 4'h8, 32'd50, 32'd7);
        bp_instr[3] = 32'h0020A063; bp_rs1[3] = 32'd4;     bp_rs2[3] = 32'd4;
        bp_exp[3]   = op(1'b1, 4'h0, 32'd0, 32'd0);
        idx = 0; got = 0; occ = 0; have_hold = 1'b0; held = '0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            in_valid  = (idx < 4);
            if (idx < 4) drive(bp_instr[idx], 32'h0, bp_rs1[idx], bp_rs2[idx]);
            #1;
`ifdef ALU_CTRL_ISSUE_SKID_EN
            exp_rdy = (occ < 2);
`else
            exp_rdy = (occ == 0) || out_ready;
`endif
            check("bp.in_ready", 69'(in_ready), 69'(exp_rdy));
            if (have_hold) begin
                check("bp.stall_valid", 69'(out_valid), 69'd1);
                check("bp.stall_op", cur_op(), held);
                have_hold = 1'b0;
            end
            out_fire = out_valid && out_ready;
            in_fire  = in_valid && in_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("bp.extra_out", 69'(out_valid), 69'd0);
                end else begin
                    check("bp.order", cur_op(), exp_q.pop_front());
                end
                got++;
            end
            if (out_valid && !out_ready) begin
                held      = cur_op();
                have_hold = 1'b1;
            end
            if (in_fire) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            occ = occ + int'(in_fire) - int'(out_fire);
            step();
            in_valid = 1'b0;
            if (idx == 4 && exp_q.size() == 0 && !out_valid) break;
        end
        check("bp.accepted", 69'(idx), 69'd4);
        check("bp.delivered", 69'(got), 69'd4);
        check("bp.leftover", 69'(exp_q.size()), 69'd0);

        // Reset while stalled with a valid op held (and a second one offered)
        out_ready = 1'b0;
        send("stall_a", 32'h40B50533, 32'h0, 32'd10, 32'd3);
        in_valid = 1'b1;
        drive(32'h00108093, 32'h0, 32'h30, 32'h0);
        step();
        in_valid = 1'b0;
        check("stall.valid", 69'(out_valid), 69'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.valid", 69'(out_valid), 69'd0);
        check("rst_mid.op", cur_op(), 69'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst.in_ready", 69'(in_ready), 69'd1);
        check("post_rst.valid", 69'(out_valid), 69'd0);
        send("post_rst", 32'h0000006F, 32'h300, 32'h0, 32'h0);
        expect_op("post_rst", op(1'b0, 4'h0, 32'h300, 32'd4));
        step();
        check("post_rst.drain", 69'(out_valid), 69'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Producer side of the ALU control interface: decodes one RV32I instruction per handshake into the 4-bit ALU_Ctrl code and both ALU operands.
- Presents them, registered, to the execute-stage ALU.
- Sits between register-read and execute, with valid/ready on both sides so the pipeline can stall.
- Flags instructions the ALU cannot serve as illegal.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ILLEGAL_CTRL, 4'b0000, ALU_Ctrl value driven with an illegal instruction (ADD, so the result is harmless).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction/operands valid
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  32  instruction address
- in_rs1  input  32  rs1 register value
- in_rs2  input  32  rs2 register value
- out_valid  output  1  decoded op valid
- out_ready  input  1  execute stage accepts
- alu_src1  output  32  ALU operand 1
- alu_src2  output  32  ALU operand 2
- ALU_Ctrl  output  4  ALU operation code
- out_illegal  output  1  op is not a supported ALU-class instruction

Behaviour:
- ALU_Ctrl codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Equivalently, ALU_Ctrl = {alt, funct3}, where alt = 1 only for SUB/SRA.
- OP (0110011):
  - src1=rs1, src2=rs2, ALU_Ctrl={instr[30],funct3}.
  - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
  - For shifts, src2 = {27'b0, rs2[4:0]}, because the ALU shifts by the full operand.
- OP-IMM (0010011):
  - src1=rs1, src2=sign-extended I immediate.
  - funct3 000 is always ADD; instr[30] is ignored.
  - Shifts use src2={27'b0,instr[24:20]} and ALU_Ctrl={instr[30],funct3}.
  - For shifts, instr[31:25] must be 0000000, or 0100000 with funct3 101; otherwise illegal.
- LOAD/STORE: ADD rs1 + I or S immediate (sign-extended).
- BRANCH:
  - BEQ/BNE: SUB on rs1,rs2.
  - BLT/BGE: SLT.
  - BLTU/BGEU: SLTU.
  - funct3 010/011 is illegal.
- LUI: ADD 0 + {imm[31:12],12'b0}.
- AUIPC: ADD pc + U immediate.
- JAL/JALR: ADD pc + 4 (link value).
- Any other opcode, or instr[1:0] != 11, is illegal.
- Illegal ops pass through the handshake with out_illegal=1, ALU_Ctrl=ILLEGAL_CTRL, and src1=src2=0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 op/cycle when out_ready is held high.
- Reset (asynchronous):
  - out_valid=0, out_illegal=0, ALU_Ctrl=0000, alu_src1=alu_src2=0.
  - Any buffered op is discarded; in_ready=1 after reset.
  - Reset mid-stall drops held ops silently.
- Simultaneous output drain and input accept in the same cycle: the new op replaces the drained one with no bubble.

Optional Feature:
- Macro ALU_CTRL_ISSUE_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer; in_ready is a flop, equal to !skid_full.
  - An op accepted while the output is stalled goes to the skid.
  - When the output drains, the skid moves to the output next edge; ordering is preserved.
  - No combinational path from out_ready to in_ready.
- Undefined:
  - Single output register only; in_ready = !out_valid || out_ready (combinational).

Decomposition:
- Shared package alu_pkg holds:
  - a typedef enum logic[3:0] of the ten ALU_Ctrl codes;
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR;
  - funct3 constants.
- One natural sub-module, alu_ctrl_decode: purely combinational, from instr/pc/rs1/rs2 to {ctrl, src1, src2, illegal}.
- The top level holds the handshake registers and the skid.

Test Plan:
- OP instruction 0x40B50533 (sub a0,a0,a1), rs1=10, rs2=3, out_ready=1 -> one cycle later out_valid=1, ALU_Ctrl=1000, src1=10, src2=3, out_illegal=0.
- SRAI 0x4041D193 (srai x3,x3,4), rs1=0xF0000000 -> ALU_Ctrl=1101, src2=4. Same word with instr[31:25]=0100001 -> out_illegal=1, ALU_Ctrl=0000.
- BLTU with rs1=1, rs2=0xFFFFFFFF -> ALU_Ctrl=0011. BEQ -> 1000. Branch funct3=010 -> out_illegal=1.
- Backpressure, 4 back-to-back ops with out_ready low for 3 cycles:
  - No op lost or duplicated; outputs are stable while stalled.
  - With ALU_CTRL_ISSUE_SKID_EN, in_ready drops only once the skid is full.
- AUIPC imm=0x12345 at pc=0x100 -> src1=0x100, src2=0x12345000, ALU_Ctrl=0000. JAL at pc=0x200 -> src1=0x200, src2=4.
- rst_n asserted low while stalled with out_valid=1 -> immediately out_valid=0, outputs 0. After release, in_ready=1 and the first new op appears with 1-cycle latency.
